// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// These are the scan state encoding, the all-segments-off pattern and the
// helper that derives the dwell length from the clock and digit rates.
package seg7_scan_pkg;

  typedef enum logic [0:0] {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_e;

  // Segment bus is active-low, so all ones means every segment is dark.
  localparam logic [6:0] SEG_ALL_OFF = 7'h7F;

  // The PWM counter runs 0..PWM_LAST and then wraps.
  // A brightness of 15 therefore never drops out.
  localparam logic [3:0] PWM_LAST = 4'd14;

  // Number of clk cycles each digit owns (blank + on), integer division.
  function automatic int dwell_cycles(input int clk_freq_hz, input int digit_rate_hz);
    return clk_freq_hz / digit_rate_hz;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the segment decoders and the scan driver.
// It carries the per-digit segment patterns in and the shared segment bus plus
// digit enables out. Optional macro SEG7_SCAN_DIMMING_EN adds the 4-bit
// brightness input.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                  i_enable;
  logic [6:0]            i_hex [0:NUM_DIGITS-1];
  logic [6:0]            o_seg;
  logic [NUM_DIGITS-1:0] o_dig;

`ifdef SEG7_SCAN_DIMMING_EN
  logic [3:0]            i_brightness;

  modport master (
    output i_enable, i_hex, i_brightness,
    input  o_seg, o_dig
  );

  modport slave (
    input  i_enable, i_hex, i_brightness,
    output o_seg, o_dig
  );
`else
  modport master (
    output i_enable, i_hex,
    input  o_seg, o_dig
  );

  modport slave (
    input  i_enable, i_hex,
    output o_seg, o_dig
  );
`endif

endinterface

// File: rtl/seg7_scan_timer.sv
// Loadable down-counter that times both the blank and the on phase of a dwell.
// tc flags the last cycle of a loaded interval (count == 1).
// idle flags a counter that has been cleared and not yet loaded (count == 0).
module seg7_scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc,
  output logic             idle
);

  logic [WIDTH-1:0] count;

  // Clear beats load, load beats decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc   = (count == WIDTH'(1));
  assign idle = (count == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes per-digit segment patterns onto one shared segment bus.
// Digit enables are one-hot, and a blanking interval opens every dwell.
// Each digit's pattern is snapshotted when the digit lights, so a display
// never tears. Optional macro SEG7_SCAN_DIMMING_EN adds PWM brightness
// gating of the digit enable.
module seg7_scan_driver
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int DIGIT_RATE_HZ  = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_driver_if.slave bus
);

  localparam int DWELL_CYCLES = dwell_cycles(CLK_FREQ_HZ, DIGIT_RATE_HZ);
  localparam int ON_CYCLES    = DWELL_CYCLES - BLANK_CYCLES;
  localparam int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = SCAN_BLANK;
  localparam logic [0:0] ST_ON    = SCAN_ON;

  localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]      ON_LOAD    = CNT_W'(ON_CYCLES);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < DWELL_CYCLES");
  end

  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  tmr_clear, tmr_load, tmr_tc, tmr_idle;
  logic [CNT_W-1:0]      tmr_value;
  logic                  lit_entry, lit_run;

  // The blank phase starts from an idle timer after reset or disable,
  // and from a loaded timer after a normal ON exit. Reloading at that exit
  // edge makes the exit cycle itself the first blank cycle.
  seg7_scan_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (tmr_clear),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc),
    .idle       (tmr_idle)
  );

  assign dig_sel = DIG_OFF ^ (DIG_ONE << idx_q);

`ifdef SEG7_SCAN_DIMMING_EN
  logic [3:0] bright_q;
  logic [3:0] pwm_q;
  logic [3:0] pwm_step;
  logic       on_entry;

  assign on_entry  = bus.i_enable && (state_q == ST_BLANK) && !tmr_idle && tmr_tc;
  assign pwm_step  = (pwm_q == PWM_LAST) ? 4'd0 : pwm_q + 4'd1;
  assign lit_entry = (bus.i_brightness != 4'd0);
  assign lit_run   = (pwm_step < bright_q);

  // Brightness is frozen with the segment snapshot and the PWM phase restarts per digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 4'd0;
      pwm_q    <= 4'd0;
    end else if (on_entry) begin
      bright_q <= bus.i_brightness;
      pwm_q    <= 4'd0;
    end else if (state_q == ST_ON) begin
      pwm_q    <= pwm_step;
    end
  end
`else
  assign lit_entry = 1'b1;
  assign lit_run   = 1'b1;
`endif

  // Next-state, next-output and timer control; disable dominates everything but reset.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seg_d     = seg_q;
    dig_d     = dig_q;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;

    if (!bus.i_enable) begin
      state_d   = ST_BLANK;
      seg_d     = SEG_ALL_OFF;
      dig_d     = DIG_OFF;
      tmr_clear = 1'b1;
    end else if (state_q == ST_BLANK) begin
      seg_d = SEG_ALL_OFF;
      dig_d = DIG_OFF;
      if (tmr_idle) begin
        tmr_load  = 1'b1;
        tmr_value = BLANK_LOAD;
      end else if (tmr_tc) begin
        state_d   = ST_ON;
        tmr_load  = 1'b1;
        tmr_value = ON_LOAD;
        seg_d     = bus.i_hex[idx_q];
        dig_d     = lit_entry ? dig_sel : DIG_OFF;
      end
    end else begin
      if (tmr_tc) begin
        state_d   = ST_BLANK;
        tmr_load  = 1'b1;
        tmr_value = BLANK_LOAD;
        seg_d     = SEG_ALL_OFF;
        dig_d     = DIG_OFF;
        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        dig_d     = lit_run ? dig_sel : DIG_OFF;
      end
    end
  end

  // State, digit index and the registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      seg_q   <= SEG_ALL_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.o_seg = seg_q;
  assign bus.o_dig = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with 4 digits, dwell 10 and blank 2.
// Expected outputs are queued per cycle, and a monitor compares them on the
// falling edge. The dimming phase is exercised when SEG7_SCAN_DIMMING_EN is
// defined.
module tb_seg7_scan_driver;
  import seg7_scan_pkg::*;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic [3:0] dig;
    string      name;
  } exp_t;

  localparam logic [3:0] DIG_NONE = 4'b1111;

  logic       clk;
  logic       rst;
  int         cyc;
  int         checks;
  int         errors;
  int         baseR;
  int         baseR2;
  exp_t       sb [$];
  logic [6:0] visitSeg [0:9];

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .CLK_FREQ_HZ    (1000),
    .DIGIT_RATE_HZ  (100),
    .BLANK_CYCLES   (2),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExp(input int c, input logic [6:0] seg, input logic [3:0] dig, input string name);
    exp_t e;
    e.cyc  = c;
    e.seg  = seg;
    e.dig  = dig;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expectOff(input int start, input int n, input string name);
    for (int i = 0; i < n; i++) pushExp(start + i, 7'h7F, DIG_NONE, name);
  endtask

  task automatic expectLit(input int start, input int n, input int digit, input logic [6:0] seg, input string name);
    logic [3:0] dig;
    dig = DIG_NONE;
    dig[digit] = 1'b0;
    for (int i = 0; i < n; i++) pushExp(start + i, seg, dig, name);
  endtask

  task automatic expectDark(input int start, input int n, input logic [6:0] seg, input string name);
    for (int i = 0; i < n; i++) pushExp(start + i, seg, DIG_NONE, name);
  endtask

  task automatic applyStimulus(input logic rstV, input logic enV);
    rst = rstV;
    bus.i_enable = enV;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (e.cyc != cyc || bus.o_seg !== e.seg || bus.o_dig !== e.dig) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d: got o_seg=%h o_dig=%b, want o_seg=%h o_dig=%b at cyc %0d",
               e.name, cyc, bus.o_seg, bus.o_dig, e.seg, e.dig, e.cyc);
    end
  endtask

  // Monitor: pop every expectation due at this cycle and compare against the DUT.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    visitSeg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h40, 7'h79, 7'h24, 7'h30, 7'h40, 7'h12};
    bus.i_hex[0] = 7'h40;
    bus.i_hex[1] = 7'h79;
    bus.i_hex[2] = 7'h24;
    bus.i_hex[3] = 7'h30;
`ifdef SEG7_SCAN_DIMMING_EN
    bus.i_brightness = 4'd15;
`endif
    applyStimulus(1'b1, 1'b1);
    expectOff(1, 3, "reset_hold");
    waitUntil(3);
    baseR  = cyc;
    baseR2 = baseR + 126;

    for (int v = 0; v < 10; v++) begin
      expectOff(baseR + 10 * v + 1, 2, $sformatf("blank_v%0d", v));
      expectLit(baseR + 10 * v + 3, 8, v % 4, visitSeg[v], $sformatf("scan_v%0d", v));
    end
    expectOff(baseR + 101, 2, "blank_pre_drop");
    expectLit(baseR + 103, 3, 2, 7'h24, "d2_before_drop");
    expectOff(baseR + 106, 5, "enable_low");
    expectOff(baseR + 111, 2, "reenable_blank");
    expectLit(baseR + 113, 8, 2, 7'h24, "d2_relit");
    expectOff(baseR + 121, 2, "blank_d3");
    expectLit(baseR + 123, 3, 3, 7'h30, "d3_before_rst");
    expectOff(baseR2, 1, "rst_pulse");
    expectOff(baseR2 + 1, 2, "restart_blank");
    expectLit(baseR2 + 3, 8, 0, 7'h40, "restart_d0");
    expectOff(baseR2 + 11, 2, "blank_d1");
    expectLit(baseR2 + 13, 8, 1, 7'h12, "d1_new_hex");
    expectOff(baseR2 + 21, 2, "blank_d2");
`ifdef SEG7_SCAN_DIMMING_EN
    expectDark(baseR2 + 23, 8, 7'h24, "dim_b0");
`else
    expectLit(baseR2 + 23, 8, 2, 7'h24, "d2_full");
`endif
    expectOff(baseR2 + 31, 2, "blank_d3b");
`ifdef SEG7_SCAN_DIMMING_EN
    expectLit(baseR2 + 33, 5, 3, 7'h30, "dim_b5_on");
    expectDark(baseR2 + 38, 3, 7'h30, "dim_b5_off");
`else
    expectLit(baseR2 + 33, 8, 3, 7'h30, "d3_full");
`endif
    expectOff(baseR2 + 41, 2, "blank_d0b");
    expectLit(baseR2 + 43, 8, 0, 7'h40, "d0_b15");

    applyStimulus(1'b0, 1'b1);
    waitUntil(baseR + 56);
    bus.i_hex[1] = 7'h12;
    waitUntil(baseR + 105);
    applyStimulus(1'b0, 1'b0);
    waitUntil(baseR + 110);
    applyStimulus(1'b0, 1'b1);
    waitUntil(baseR + 125);
    applyStimulus(1'b1, 1'b1);
    waitUntil(baseR2);
    applyStimulus(1'b0, 1'b1);
`ifdef SEG7_SCAN_DIMMING_EN
    waitUntil(baseR2 + 20);
    bus.i_brightness = 4'd0;
    waitUntil(baseR2 + 30);
    bus.i_brightness = 4'd5;
    waitUntil(baseR2 + 40);
    bus.i_brightness = 4'd15;
`endif
    waitUntil(baseR2 + 52);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates with a summary.
  initial begin
    #20000;
    errors++;
    $display("[TB] FAIL timeout: got cyc=%0d, want completion before 20000ns", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream stage of the memory-mapped 7-segment controller. It takes the per-digit segment patterns produced by the seg7 decoders and time-multiplexes them onto a single shared segment bus with one-hot digit enables. This suits boards with multiplexed common-anode or common-cathode displays. Each digit transition has a blanking interval to suppress ghosting, and each digit's pattern is snapshotted so the display never tears.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..8).
CLK_FREQ_HZ, 50000000, clk frequency.
DIGIT_RATE_HZ, 1000, digit-advance rate; DWELL_CYCLES = CLK_FREQ_HZ/DIGIT_RATE_HZ (integer division).
BLANK_CYCLES, 16, all-off cycles at the start of each dwell; elaboration error unless 1 <= BLANK_CYCLES < DWELL_CYCLES.
DIG_ACTIVE_LOW, 1, 1: o_dig bit low = digit on.

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset is synchronous and active-high
i_enable  input  1  scan enable; low forces all digits off
i_hex  input  7 x [0:NUM_DIGITS-1]  segment patterns from the decoders, active-low (bit=0 lit)
o_seg  output  7  shared segment bus, active-low
o_dig  output  NUM_DIGITS  digit enables, polarity set by DIG_ACTIVE_LOW

Behaviour:
- All outputs are registered.
- Reset values: o_seg=7'h7F; o_dig=all inactive; state=BLANK; digit index=0; dwell counter=0.
- States:
  - BLANK: o_dig all inactive, o_seg=7'h7F. Lasts BLANK_CYCLES cycles, then goes to ON.
  - ON: o_dig has only the bit for the current index active. o_seg holds the snapshot of i_hex[index], captured on the BLANK->ON transition cycle. ON lasts DWELL_CYCLES-BLANK_CYCLES cycles.
  - ON exit: index increments and wraps NUM_DIGITS-1 -> 0, then the state returns to BLANK.
- Scan period is NUM_DIGITS*DWELL_CYCLES. With NUM_DIGITS=1 the index stays 0.
- The first ON output appears BLANK_CYCLES+1 cycles after rst deasserts.
- Changes to i_hex during ON are invisible until that digit's next ON entry.
- i_enable low:
  - Next cycle, outputs go inactive and the state goes to BLANK with the counter cleared.
  - The index is held.
  - On re-enable, a full BLANK precedes ON of the held index.
- rst mid-operation: next cycle matches the reset values regardless of state.
- rst and i_enable asserted together: rst wins.
- Dwell counter width: $clog2(DWELL_CYCLES). Index width: $clog2(NUM_DIGITS), minimum 1.

Optional Feature:
SEG7_SCAN_DIMMING_EN
- Defined:
  - Adds port i_brightness (input, 4 bits).
  - Brightness is captured at ON entry, alongside the segment snapshot.
  - A 4-bit PWM counter clears at ON entry and counts 0..14 mod 15.
  - During ON, o_dig is active only while pwm_cnt < brightness. 0 means never lit; 15 means always lit.
  - o_seg behaves exactly as without the feature.
- Undefined: the port is absent and the digit is active for the whole ON phase.

Decomposition:
- Package seg7_scan_pkg:
  - Typedef enum of scan states (SCAN_BLANK, SCAN_ON).
  - Constant SEG_ALL_OFF = 7'h7F.
  - Function computing dwell cycles from the two frequency parameters.
- Sub-module seg7_scan_timer: loadable down-counter with a terminal-count pulse and synchronous clear. It serves as the dwell/blank timer, instantiated once.

Test Plan:
Common bench setup: NUM_DIGITS=4, CLK_FREQ_HZ=1000, DIGIT_RATE_HZ=100 (DWELL=10), BLANK_CYCLES=2, DIG_ACTIVE_LOW=1.
1. Reset: hold rst 3 cycles -> o_dig=4'b1111, o_seg=7'h7F. After release, 2 cycles off; on cycle 3, o_dig=4'b1110 and o_seg=i_hex[0].
2. Full scan, i_hex={7'h40,7'h79,7'h24,7'h30} -> digits 0..3 each lit 8 cycles, separated by 2 blank cycles. Digit 0 relit at cycle 43.
3. Snapshot: change i_hex[1] from 7'h79 to 7'h12 at the 4th ON cycle of digit 1 -> o_seg stays 7'h79 for that dwell and shows 7'h12 on the next visit.
4. Enable drop at ON cycle 3 of digit 2 -> next cycle all off. Re-enable after 5 cycles -> 2 blank cycles, then digit 2 relit.
5. Reset pulse during ON of digit 3 -> next cycle outputs inactive. Scan restarts at digit 0 after 2 blank cycles.
6. Dimming (macro defined): brightness 0 -> o_dig never active. Brightness 15 -> active for all 8 ON cycles. Brightness 5 -> active for ON cycles 1-5, inactive for 6-8.
